// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/decode/execute/writeback sequencer driving an external alu and owning W, file bank, pc and flags
module alu_sequencer #(
  parameter int PC_W = 8,
  parameter int FA_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic [3:0]      alu_inst,
  output logic [15:0]     alu_f,
  output logic [15:0]     alu_w,
  input  logic [16:0]     alu_ans,
  output logic [15:0]     w_out,
  output logic            carry,
  output logic            zero,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            illegal,
  input  logic [FA_W-1:0] dbg_addr,
  output logic [15:0]     dbg_data
);
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK, HALT} state_t;
  localparam logic [3:0] NOP = 4'b1000;
  state_t r_state;
  logic [15:0] r_ir, r_w, r_f, r_walu;
  logic [16:0] r_ans;
  logic [15:0] r_file [2**FA_W];
  logic [PC_W-1:0] r_pc;
  logic [3:0] r_inst;
  logic r_req, r_c, r_z, r_halted, r_illegal;
  logic [3:0] w_op;
  logic w_d, w_wr, w_to_file, w_upd_c, w_upd_z, w_unused;
  logic [FA_W-1:0] w_a;
  logic [15:0] w_res;
  assign w_op = r_ir[15:12];
  assign w_d = r_ir[11];
  assign w_a = r_ir[FA_W-1:0];
  assign w_unused = ^r_ir[10:FA_W];
  // movwf stores W itself and clrw forces zero; every other writing op takes the alu result
  assign w_res = w_op == 4'd9 ? 16'h0000 : w_op == 4'd1 ? r_w : r_ans[15:0];
  assign w_wr = w_op <= 4'd10 && w_op != 4'd8;
  assign w_to_file = w_op == 4'd1 || (w_op != 4'd9 && w_d);
  assign w_upd_c = w_op inside {4'd2, 4'd3, 4'd5, 4'd6};
  assign w_upd_z = w_wr && w_op != 4'd1;
  assign imem_req = r_req;
  assign imem_addr = r_pc;
  assign pc = r_pc;
  assign alu_inst = r_inst;
  assign alu_f = r_f;
  assign alu_w = r_walu;
  assign w_out = r_w;
  assign carry = r_c;
  assign zero = r_z;
  assign halted = r_halted;
  assign illegal = r_illegal;
  assign dbg_data = r_file[dbg_addr];
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= FETCH;
      r_pc <= '0;
      r_w <= '0;
      r_c <= 1'b0;
      r_z <= 1'b0;
      r_halted <= 1'b0;
      r_illegal <= 1'b0;
      r_req <= 1'b0;
      r_inst <= NOP;
      r_f <= '0;
      r_walu <= '0;
      r_ir <= '0;
      r_ans <= '0;
      for (int i = 0; i < 2**FA_W; i++) r_file[i] <= '0;
    end else begin
      r_illegal <= 1'b0;
      case (r_state)
        FETCH: begin
          // ack only counts once the request is visible on the port
          if (r_req && imem_ack) begin
            r_ir <= imem_data;
            r_req <= 1'b0;
            r_state <= DECODE;
          end else r_req <= 1'b1;
        end
        DECODE: begin
          r_f <= r_file[w_a];
          r_walu <= r_w;
          r_inst <= w_op <= 4'd10 ? w_op : NOP;
          r_state <= EXECUTE;
        end
        EXECUTE: begin
          r_ans <= alu_ans;
          r_inst <= NOP;
          r_state <= WRITEBACK;
        end
        WRITEBACK: begin
          if (w_op == 4'd15) begin
            r_halted <= 1'b1;
            r_state <= HALT;
          end else begin
            r_pc <= r_pc + 1'b1;
            r_req <= 1'b1;
            r_state <= FETCH;
            r_illegal <= w_op inside {[4'd11:4'd14]};
            if (w_wr && w_to_file) r_file[w_a] <= w_res;
            if (w_wr && !w_to_file) r_w <= w_res;
            if (w_upd_c) r_c <= r_ans[16];
            if (w_upd_z) r_z <= w_res == 16'h0000;
          end
        end
        default: r_state <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: random and directed instruction streams checked against a spec-level model of W/file/flags/pc
module tb_alu_sequencer;
  logic clk = 0, reset = 0, imem_req, imem_ack = 0;
  logic [7:0] imem_addr, pc;
  logic [15:0] imem_data = 0, alu_f, alu_w, w_out, dbg_data;
  logic [3:0] alu_inst, dbg_addr = 0;
  logic [16:0] alu_ans;
  logic carry, zero, halted, illegal;
  int n_cmp = 0, n_err = 0;
  logic [15:0] m_file [16];
  logic [15:0] m_w;
  logic m_c, m_z, m_halt, m_ill;
  logic [7:0] m_pc;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .alu_inst(alu_inst), .alu_f(alu_f), .alu_w(alu_w), .alu_ans(alu_ans),
    .w_out(w_out), .carry(carry), .zero(zero), .pc(pc), .halted(halted), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // behavioural alu sitting on the other side of the operand interface
  always_comb begin
    alu_ans = '0;
    case (alu_inst)
      4'd0: alu_ans = {1'b0, alu_f};
      4'd1: alu_ans = {1'b0, alu_w};
      4'd2: alu_ans = {1'b0, alu_f} + {1'b0, alu_w};
      4'd3: alu_ans = {alu_w < alu_f, alu_w - alu_f};
      4'd4: alu_ans = {1'b0, alu_f & alu_w};
      4'd5: alu_ans = {alu_f == 16'hFFFF, alu_f + 16'd1};
      4'd6: alu_ans = {alu_f == 16'h0000, alu_f - 16'd1};
      4'd7: alu_ans = {1'b0, alu_f ^ alu_w};
      4'd10: alu_ans = {1'b0, alu_f | alu_w};
      default: alu_ans = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset;
    foreach (m_file[i]) m_file[i] = 0;
    m_w = 0; m_c = 0; m_z = 0; m_pc = 0; m_halt = 0; m_ill = 0;
  endtask

  task automatic model_step(input logic [15:0] ins);
    int op, a, f, r, cy;
    op = ins[15:12]; a = ins[3:0]; f = m_file[a]; r = 0; cy = 0;
    m_ill = op >= 11 && op <= 14;
    if (op == 15) begin m_halt = 1; return; end
    m_pc = m_pc + 8'd1;
    case (op)
      0: r = f;
      2: begin r = (f + m_w) % 65536; cy = (f + m_w) > 65535; end
      3: begin r = (m_w - f + 65536) % 65536; cy = m_w < f; end
      4: r = f & m_w;
      5: begin r = (f + 1) % 65536; cy = f == 65535; end
      6: begin r = (f + 65535) % 65536; cy = f == 0; end
      7: r = f ^ m_w;
      10: r = f | m_w;
      default: r = 0;
    endcase
    if (op == 1) m_file[a] = m_w;
    else if (op == 9) begin m_w = 0; m_z = 1; end
    else if (op <= 10 && op != 8) begin
      if (ins[11]) m_file[a] = r[15:0]; else m_w = r[15:0];
      m_z = r == 0;
      if (op inside {2, 3, 5, 6}) m_c = cy[0];
    end
  endtask

  task automatic exec(input logic [15:0] ins, input int stall);
    int n;
    n = 0;
    dbg_addr = ins[3:0];
    while (!imem_req && n < 50) begin @(negedge clk); n++; end
    if (!imem_req) begin check("req_timeout", 0, 1); return; end
    check("addr", imem_addr, m_pc);
    repeat (stall) begin
      @(negedge clk);
      check("stall_req", imem_req, 1);
      check("stall_addr", imem_addr, m_pc);
    end
    imem_ack = 1; imem_data = ins;
    @(negedge clk);
    imem_ack = 0; imem_data = 16'($urandom);
    repeat (3) @(negedge clk);
    model_step(ins);
    check("w", w_out, m_w);
    check("carry", carry, m_c);
    check("zero", zero, m_z);
    check("pc", pc, m_pc);
    check("halted", halted, m_halt);
    check("illegal", illegal, m_ill);
    check("file", dbg_data, m_file[ins[3:0]]);
  endtask

  function automatic logic [15:0] ins(input int op, input int d, input int a);
    logic [6:0] junk;
    junk = 7'($urandom);
    return {op[3:0], d[0], junk, a[3:0]};
  endfunction

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_pc", pc, 0);
    check("rst_w", w_out, 0);
    check("rst_flags", {carry, zero, halted, illegal}, 0);
    check("rst_req", imem_req, 0);
    reset = 1;
    exec(ins(5, 1, 9), 0);
    exec(ins(5, 0, 9), 1);
    // sitting in fetch with req high when reset is re-applied
    reset = 0;
    repeat (3) @(negedge clk);
    dbg_addr = 9;
    #1;
    check("mid_rst_pc", pc, 0);
    check("mid_rst_w", w_out, 0);
    check("mid_rst_flags", {carry, zero}, 0);
    check("mid_rst_req", imem_req, 0);
    check("mid_rst_file", dbg_data, 0);
    model_reset();
    reset = 1;
    @(negedge clk);
    exec(ins(9, 0, 0), 0);
    repeat (5) exec(ins(5, 1, 3), 0);
    exec(ins(2, 0, 3), 0);
    exec(ins(2, 0, 3), 0);
    check("add_w", w_out, 16'h000A);
    exec(ins(1, 0, 7), 0);
    exec(ins(9, 1, 0), 0);
    exec(ins(6, 0, 0), 0);
    exec(ins(5, 1, 1), 0);
    exec(ins(2, 1, 1), 0);
    check("wrap_file", dbg_data, 0);
    check("wrap_flags", {carry, zero}, 2'b11);
    check("wrap_w", w_out, 16'hFFFF);
    repeat (3) exec(ins(5, 1, 5), 0);
    exec(ins(0, 0, 5), 0);
    repeat (4) exec(ins(5, 1, 2), 0);
    exec(ins(3, 0, 2), 0);
    check("borrow_w", w_out, 16'hFFFF);
    check("borrow_flags", {carry, zero}, 2'b10);
    exec(ins(12, 1, 4), 0);
    @(negedge clk);
    check("illegal_pulse", illegal, 0);
    for (int k = 0; k < 400 && m_pc != 8'hFF; k++)
      exec(ins($urandom_range(0, 14), $urandom_range(0, 1), $urandom_range(0, 15)), $urandom_range(0, 3));
    check("pc_ff", pc, 8'hFF);
    exec(ins(8, 0, 0), 5);
    check("pc_wrap", pc, 0);
    exec(ins(15, 0, 0), 0);
    repeat (10) begin
      @(negedge clk);
      check("halt_req", imem_req, 0);
      check("halt_pc", pc, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
